// File: rtl/instr_fetch_stage_pkg.sv
// Shared MIPS definitions for the fetch stage.
// Holds the default datapath widths, the NOP/HALT instruction encodings
// and the fetch FSM state type used by instr_fetch_stage.
package instr_fetch_stage_pkg;

    localparam int NB_PC_DEF        = 32;
    localparam int NB_INSTR_DEF     = 32;
    localparam int NB_IMEM_ADDR_DEF = 10;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam logic [31:0] INSTR_HALT = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Bundle of every fetch-stage signal except clock and reset.
//   slave  : view of the fetch stage (consumes i_*, drives o_*)
//   master : view of the surrounding pipeline / memory (drives i_*)
// Signals:
//   i_valid, i_hazard             step enable and stall request
//   i_branch_taken/_target        taken-branch redirect from ID
//   i_jump/_target                jump redirect from ID
//   o_imem_addr, i_imem_data      combinational instruction memory read
//   o_pc                          current fetch PC
//   o_if_id_instr/_pc_next/_valid IF/ID pipeline register
//   o_halted, o_cycle_count       status
interface instr_fetch_stage_if
    import instr_fetch_stage_pkg::*;
#(
    parameter int NB_PC        = NB_PC_DEF,
    parameter int NB_INSTR     = NB_INSTR_DEF,
    parameter int NB_IMEM_ADDR = NB_IMEM_ADDR_DEF
);
    logic                    i_valid;
    logic                    i_hazard;
    logic                    i_branch_taken;
    logic [NB_PC-1:0]        i_branch_target;
    logic                    i_jump;
    logic [NB_PC-1:0]        i_jump_target;
    logic [NB_IMEM_ADDR-1:0] o_imem_addr;
    logic [NB_INSTR-1:0]     i_imem_data;
    logic [NB_PC-1:0]        o_pc;
    logic [NB_INSTR-1:0]     o_if_id_instr;
    logic [NB_PC-1:0]        o_if_id_pc_next;
    logic                    o_if_id_valid;
    logic                    o_halted;
    logic [31:0]             o_cycle_count;

    modport slave (
        input  i_valid, i_hazard, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_imem_data,
        output o_imem_addr, o_pc, o_if_id_instr, o_if_id_pc_next,
               o_if_id_valid, o_halted, o_cycle_count
    );

    modport master (
        output i_valid, i_hazard, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_imem_data,
        input  o_imem_addr, o_pc, o_if_id_instr, o_if_id_pc_next,
               o_if_id_valid, o_halted, o_cycle_count
    );
endinterface

// File: rtl/instr_fetch_stage_pc_unit.sv
// pc_unit: program counter register and next-PC selection.
// Ports:
//   i_clock, i_reset     clock and synchronous active-high reset
//   i_advance            load the selected next PC this cycle
//   i_branch_taken/_tgt  highest-priority redirect
//   i_jump/_tgt          second-priority redirect
//   o_pc                 current PC
//   o_pc_plus4           sequential successor (wraps modulo 2^NB_PC)
module pc_unit #(
    parameter int               NB_PC    = 32,
    parameter logic [NB_PC-1:0] RESET_PC = '0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_advance,
    input  logic             i_branch_taken,
    input  logic [NB_PC-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [NB_PC-1:0] i_jump_target,
    output logic [NB_PC-1:0] o_pc,
    output logic [NB_PC-1:0] o_pc_plus4
);
    logic [NB_PC-1:0] pc_reg;
    logic [NB_PC-1:0] pc_next;
    logic [NB_PC-1:0] pc_plus4;

    assign pc_plus4 = pc_reg + NB_PC'(4);

    // Branch beats jump; targets are taken as-is, alignment is not checked.
    always_comb begin
        pc_next = pc_plus4;
        if (i_branch_taken) begin
            pc_next = i_branch_target;
        end else if (i_jump) begin
            pc_next = i_jump_target;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_reg <= RESET_PC;
        end else if (i_advance) begin
            pc_reg <= pc_next;
        end
    end

    assign o_pc       = pc_reg;
    assign o_pc_plus4 = pc_plus4;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: MIPS instruction fetch with IF/ID register.
// Ports:
//   i_clock  single rising-edge clock
//   i_reset  synchronous active-high reset, overrides everything
//   bus      instr_fetch_stage_if.slave (handshake, redirects, imem, IF/ID,
//            status)
// Behaviour: in RUN, each i_valid cycle without hazard captures the fetched
// word into IF/ID and moves the PC (branch > jump > PC+4). Fetching HALT
// captures it, freezes the PC and enters HALTED, which only reset leaves;
// while halted, every i_valid cycle pushes a bubble into IF/ID.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int               NB_PC        = NB_PC_DEF,
    parameter int               NB_INSTR     = NB_INSTR_DEF,
    parameter int               NB_IMEM_ADDR = NB_IMEM_ADDR_DEF,
    parameter logic [NB_PC-1:0] RESET_PC     = '0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    instr_fetch_stage_if.slave   bus
);
    fetch_state_t            state_reg;
    logic [NB_INSTR-1:0]     if_id_instr_reg;
    logic [NB_PC-1:0]        if_id_pc_next_reg;
    logic                    if_id_valid_reg;
    logic                    halted_reg;
    logic [31:0]             cycle_count_reg;

    logic [NB_PC-1:0]        pc;
    logic [NB_PC-1:0]        pc_plus4;
    logic [NB_IMEM_ADDR-1:0] imem_addr;
    logic                    fetch_step;
    logic                    fetch_is_halt;
    logic                    pc_advance;

    // A real fetch happens only when running, stepped and not stalled.
    assign fetch_step    = (state_reg == ST_RUN) && bus.i_valid && !bus.i_hazard;
    assign fetch_is_halt = (bus.i_imem_data == NB_INSTR'(INSTR_HALT));
    // The HALT word itself is consumed but the PC stays on it.
    assign pc_advance    = fetch_step && !fetch_is_halt;

    pc_unit #(
        .NB_PC    (NB_PC),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_advance       (pc_advance),
        .i_branch_taken  (bus.i_branch_taken),
        .i_branch_target (bus.i_branch_target),
        .i_jump          (bus.i_jump),
        .i_jump_target   (bus.i_jump_target),
        .o_pc            (pc),
        .o_pc_plus4      (pc_plus4)
    );

    // Word address: drop the byte offset, ignore bits above memory depth.
    genvar gi;
    generate
        for (gi = 0; gi < NB_IMEM_ADDR; gi++) begin : g_imem_addr
            assign imem_addr[gi] = pc[gi + 2];
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg         <= ST_RUN;
            if_id_instr_reg   <= NB_INSTR'(INSTR_NOP);
            if_id_pc_next_reg <= '0;
            if_id_valid_reg   <= 1'b0;
            halted_reg        <= 1'b0;
            cycle_count_reg   <= '0;
        end else if (bus.i_valid) begin
            case (state_reg)
                ST_RUN: begin
                    // Counts stalled cycles too; saturates instead of wrapping.
                    if (cycle_count_reg != 32'hFFFF_FFFF) begin
                        cycle_count_reg <= cycle_count_reg + 32'd1;
                    end
                    if (!bus.i_hazard) begin
                        if_id_instr_reg   <= bus.i_imem_data;
                        if_id_pc_next_reg <= pc_plus4;
                        if_id_valid_reg   <= 1'b1;
                        if (fetch_is_halt) begin
                            state_reg  <= ST_HALTED;
                            halted_reg <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    if_id_instr_reg   <= NB_INSTR'(INSTR_NOP);
                    if_id_pc_next_reg <= '0;
                    if_id_valid_reg   <= 1'b0;
                end
                default: begin
                    state_reg  <= ST_RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_imem_addr     = imem_addr;
    assign bus.o_pc            = pc;
    assign bus.o_if_id_instr   = if_id_instr_reg;
    assign bus.o_if_id_pc_next = if_id_pc_next_reg;
    assign bus.o_if_id_valid   = if_id_valid_reg;
    assign bus.o_halted        = halted_reg;
    assign bus.o_cycle_count   = cycle_count_reg;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage. Inputs change #1 after the rising
// edge and outputs are checked there, well away from the next edge.
module tb_instr_fetch_stage;
    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    instr_fetch_stage_if bus ();

    instr_fetch_stage dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pcn, input logic vld, input logic hlt,
                             input logic [31:0] cnt);
        chk({tag, ".pc"},      64'(bus.o_pc),            64'(pc));
        chk({tag, ".instr"},   64'(bus.o_if_id_instr),   64'(instr));
        chk({tag, ".pc_next"}, 64'(bus.o_if_id_pc_next), 64'(pcn));
        chk({tag, ".valid"},   64'(bus.o_if_id_valid),   64'(vld));
        chk({tag, ".halted"},  64'(bus.o_halted),        64'(hlt));
        chk({tag, ".count"},   64'(bus.o_cycle_count),   64'(cnt));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst                 = 1'b1;
        bus.i_valid         = 1'b0;
        bus.i_hazard        = 1'b0;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = '0;
        bus.i_jump          = 1'b0;
        bus.i_jump_target   = '0;
        bus.i_imem_data     = 32'h2001_0005;

        // Reset with valid high: reset must win.
        bus.i_valid = 1'b1;
        step();
        rst = 1'b0;
        chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        chk("reset.imem_addr", 64'(bus.o_imem_addr), 64'h0);

        // Three sequential fetches.
        step();
        chk_state("seq1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 32'd1);
        step();
        chk_state("seq2", 32'h8, 32'h2001_0005, 32'h8, 1'b1, 1'b0, 32'd2);
        step();
        chk_state("seq3", 32'hC, 32'h2001_0005, 32'hC, 1'b1, 1'b0, 32'd3);

        // Jump to 0x10.
        bus.i_jump = 1'b1; bus.i_jump_target = 32'h10;
        step();
        chk_state("jmp10", 32'h10, 32'h2001_0005, 32'h10, 1'b1, 1'b0, 32'd4);

        // Stall two cycles; the redirect and new imem data are ignored.
        bus.i_hazard = 1'b1; bus.i_jump_target = 32'h80; bus.i_imem_data = 32'hDEAD_BEEF;
        step();
        chk_state("stall1", 32'h10, 32'h2001_0005, 32'h10, 1'b1, 1'b0, 32'd5);
        step();
        chk_state("stall2", 32'h10, 32'h2001_0005, 32'h10, 1'b1, 1'b0, 32'd6);

        // Jump to 0x20.
        bus.i_hazard = 1'b0; bus.i_jump_target = 32'h20; bus.i_imem_data = 32'h1111_1111;
        step();
        chk_state("jmp20", 32'h20, 32'h1111_1111, 32'h14, 1'b1, 1'b0, 32'd7);

        // Branch and jump together: branch wins, delay slot captured.
        bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h100;
        bus.i_jump_target = 32'h200; bus.i_imem_data = 32'h2222_2222;
        step();
        chk_state("br_vs_jmp", 32'h100, 32'h2222_2222, 32'h24, 1'b1, 1'b0, 32'd8);

        // Jump to 0x30.
        bus.i_branch_taken = 1'b0; bus.i_jump_target = 32'h30;
        step();
        chk_state("jmp30", 32'h30, 32'h2222_2222, 32'h104, 1'b1, 1'b0, 32'd9);

        // Branch during stall is ignored, then taken once the stall lifts.
        bus.i_jump = 1'b0; bus.i_hazard = 1'b1;
        bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h300;
        bus.i_imem_data = 32'h3333_3333;
        step();
        chk_state("br_stall", 32'h30, 32'h2222_2222, 32'h104, 1'b1, 1'b0, 32'd10);
        bus.i_hazard = 1'b0;
        step();
        chk_state("br_after", 32'h300, 32'h3333_3333, 32'h34, 1'b1, 1'b0, 32'd11);

        // i_valid low: nothing moves whatever the other inputs do.
        bus.i_valid = 1'b0; bus.i_hazard = 1'b1; bus.i_branch_target = 32'h500;
        bus.i_imem_data = 32'h5555_5555;
        step();
        bus.i_hazard = 1'b0; bus.i_branch_taken = 1'b0; bus.i_jump = 1'b1;
        step();
        chk_state("novalid", 32'h300, 32'h3333_3333, 32'h34, 1'b1, 1'b0, 32'd11);

        // PC wrap at the top of the address space.
        bus.i_valid = 1'b1; bus.i_jump = 1'b1; bus.i_jump_target = 32'hFFFF_FFFC;
        step();
        chk_state("to_top", 32'hFFFF_FFFC, 32'h5555_5555, 32'h304, 1'b1, 1'b0, 32'd12);
        chk("top.imem_addr", 64'(bus.o_imem_addr), 64'h3FF);
        bus.i_jump = 1'b0;
        step();
        chk_state("wrap", 32'h0, 32'h5555_5555, 32'h0, 1'b1, 1'b0, 32'd13);
        chk("wrap.imem_addr", 64'(bus.o_imem_addr), 64'h0);

        // HALT at 0x40.
        bus.i_jump = 1'b1; bus.i_jump_target = 32'h40;
        step();
        chk_state("jmp40", 32'h40, 32'h5555_5555, 32'h4, 1'b1, 1'b0, 32'd14);
        chk("jmp40.imem_addr", 64'(bus.o_imem_addr), 64'h10);
        bus.i_jump = 1'b0; bus.i_imem_data = 32'hFFFF_FFFF;
        step();
        chk_state("halt", 32'h40, 32'hFFFF_FFFF, 32'h44, 1'b1, 1'b1, 32'd14 + 32'd1);
        bus.i_imem_data = 32'h4444_4444; bus.i_branch_taken = 1'b1;
        bus.i_branch_target = 32'h900; bus.i_hazard = 1'b1;
        step();
        chk_state("halted_bub", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 32'd15);
        bus.i_hazard = 1'b0;
        step();
        chk_state("halted_hold", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 32'd15);

        // Reset out of HALTED.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_state("rst_halt", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        // Back in RUN; then reset in the middle of a stall.
        bus.i_branch_taken = 1'b0; bus.i_imem_data = 32'h6666_6666;
        step();
        chk_state("rerun", 32'h4, 32'h6666_6666, 32'h4, 1'b1, 1'b0, 32'd1);
        bus.i_hazard = 1'b1;
        step();
        chk_state("stall_pre_rst", 32'h4, 32'h6666_6666, 32'h4, 1'b1, 1'b0, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_state("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter NB_PC, default 32: program counter and target width.
REQ-002 Parameter NB_INSTR, default 32: instruction width.
REQ-003 Parameter NB_IMEM_ADDR, default 10: instruction memory word-address width.
REQ-004 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 Port i_clock, input, 1: single clock; all state updates on rising edge.
REQ-006 Port i_reset, input, 1: synchronous, active-high reset.
REQ-007 i_valid  input  1  pipeline step enable; no state changes while low.
REQ-008 i_hazard  input  1  stall request from the hazard unit.
REQ-009 i_branch_taken  input  1  taken-branch redirect from ID.
REQ-010 i_branch_target  input  NB_PC  branch target byte address.
REQ-011 i_jump  input  1  jump redirect from ID.
REQ-012 i_jump_target  input  NB_PC  jump target byte address.
REQ-013 o_imem_addr  output  NB_IMEM_ADDR  word address to instruction memory (combinational read).
REQ-014 i_imem_data  input  NB_INSTR  instruction at o_imem_addr, same cycle.
REQ-015 o_pc  output  NB_PC  current fetch PC.
REQ-016 o_if_id_instr  output  NB_INSTR  IF/ID register instruction.
REQ-017 o_if_id_pc_next  output  NB_PC  IF/ID register PC+4.
REQ-018 o_if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-019 o_halted  output  1  fetch stopped on HALT.
REQ-020 o_cycle_count  output  32  count of stepped cycles while running.

Function
REQ-021 o_imem_addr SHALL equal PC[NB_IMEM_ADDR+1:2]; upper PC bits ignored, so addresses wrap modulo memory depth.
REQ-022 FSM SHALL have states RUN and HALTED; reset enters RUN.
REQ-023 RUN, i_valid=1, i_hazard=1: PC and IF/ID registers SHALL hold; redirect inputs SHALL be ignored that cycle.
REQ-024 RUN, i_valid=1, i_hazard=0: IF/ID SHALL load {i_imem_data, PC+4, valid=1} (delay-slot semantics, no flush on redirect).
REQ-025 Same cycle, PC next SHALL be: i_branch_target if i_branch_taken; else i_jump_target if i_jump; else PC+4 (branch wins over jump).
REQ-026 PC+4 SHALL wrap modulo 2^NB_PC; targets SHALL load unmodified (low 2 bits not checked).
REQ-027 If i_imem_data equals HALT in an advancing RUN cycle, IF/ID SHALL capture it, PC SHALL hold, FSM SHALL go to HALTED.
REQ-028 HALTED: PC frozen; each i_valid cycle IF/ID SHALL load {NOP, 0, valid=0}; i_hazard and redirects ignored; exit only by reset.
REQ-029 o_halted SHALL be 1 exactly while state is HALTED (registered).
REQ-030 o_cycle_count SHALL increment on every i_valid cycle in RUN (stalled or not), saturating at 0xFFFFFFFF; frozen in HALTED.
REQ-031 i_valid=0: all registers including counter SHALL hold regardless of other inputs.

Reset
REQ-032 i_reset SHALL take priority over i_valid and all other inputs.
REQ-033 Reset values: PC=RESET_PC, o_if_id_instr=NOP, o_if_id_pc_next=0, o_if_id_valid=0, o_halted=0, o_cycle_count=0, state RUN.
REQ-034 Reset asserted mid-stall or in HALTED SHALL give the same result as reset from idle, in one cycle.

Structure
REQ-035 NOP (32'h0000_0000) and HALT (32'hFFFF_FFFF) encodings and NB_* defaults SHALL live in the shared MIPS definitions package.
REQ-036 PC register and next-PC selection SHALL be a sub-module pc_unit; IF/ID register, FSM and counter stay in instr_fetch_stage.

Verification
REQ-037 Reset, then 3 valid cycles with imem returning 0x2001_0005 -> PC 0x0,0x4,0x8,0xC; IF/ID pc_next 0x4,0x8,0xC; valid=1; count=3.
REQ-038 PC=0x10, i_hazard=1 for 2 valid cycles -> PC stays 0x10, IF/ID unchanged, count +2.
REQ-039 PC=0x20, i_branch_taken=1 target 0x100, i_jump=1 target 0x200 -> PC=0x100; IF/ID holds instruction from 0x20, pc_next 0x24.
REQ-040 PC=0x30, i_hazard=1 with i_branch_taken=1 -> PC stays 0x30; next cycle hazard=0, branch still asserted -> PC=target.
REQ-041 imem returns HALT at PC=0x40 -> IF/ID=HALT, o_halted=1 next cycle, PC stays 0x40; following valid cycle IF/ID valid=0; count frozen; reset -> PC=RESET_PC, o_halted=0.
REQ-042 PC=0xFFFF_FFFC, advance -> PC=0x0; o_imem_addr=0x3FF before, 0x000 after; i_valid=0 with hazard/branch toggling -> no state change.
